// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: pixel enable from the consumer, position/sync/strobes from the generator.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 8
);
  logic               en;
  logic [CNT_W-1:0]   pix_x;
  logic [CNT_W-1:0]   pix_y;
  logic               de;
  logic               hs;
  logic               vs;
  logic               sof;
  logic               eol;
  logic               eof;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  en,
    output pix_x, pix_y, de, hs, vs, sof, eol, eof, frame_cnt
  );

  modport slave (
    output en,
    input  pix_x, pix_y, de, hs, vs, sof, eol, eof, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator advancing on a pixel-clock enable.
// Position and frame count are registered once; sync/enable/strobes get PIPE_DLY extra stages.
module vga_timing_gen #(
  parameter int   H_DISP   = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_DISP   = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIPE_DLY = 0,
  parameter int   CNT_W    = 10,
  parameter int   FRAME_W  = 8
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;

  // Extended-width bounds so a total of exactly 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0]   H_DISP_C  = (CNT_W+1)'(H_DISP);
  localparam logic [CNT_W:0]   HS_BEG_C  = (CNT_W+1)'(H_DISP + H_FRONT);
  localparam logic [CNT_W:0]   HS_END_C  = (CNT_W+1)'(H_DISP + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0]   V_DISP_C  = (CNT_W+1)'(V_DISP);
  localparam logic [CNT_W:0]   VS_BEG_C  = (CNT_W+1)'(V_DISP + V_FRONT);
  localparam logic [CNT_W:0]   VS_END_C  = (CNT_W+1)'(V_DISP + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DLAST_C = CNT_W'(H_DISP - 1);
  localparam logic [CNT_W-1:0] V_DLAST_C = CNT_W'(V_DISP - 1);

  // Control word order: {de, hs, vs, sof, eol, eof}, hs/vs held at their line level.
  localparam logic [5:0] IDLE_C = {1'b0, ~HS_POL, ~VS_POL, 3'b000};

  logic [CNT_W-1:0]   h_r;
  logic [CNT_W-1:0]   v_r;
  logic [CNT_W-1:0]   pix_x_r;
  logic [CNT_W-1:0]   pix_y_r;
  logic [FRAME_W-1:0] frame_cnt_r;
  logic [5:0]         ctl_r [0:PIPE_DLY];

  logic [CNT_W:0] h_ext_s;
  logic [CNT_W:0] v_ext_s;
  logic           h_last_s;
  logic           v_last_s;
  logic           hs_act_s;
  logic           vs_act_s;
  logic [5:0]     ctl_s;

  // Decode of the current raster position into the undelayed control word.
  always_comb begin
    h_ext_s  = {1'b0, h_r};
    v_ext_s  = {1'b0, v_r};
    h_last_s = (h_r == H_LAST_C);
    v_last_s = (v_r == V_LAST_C);
    hs_act_s = (h_ext_s >= HS_BEG_C) && (h_ext_s < HS_END_C);
    vs_act_s = (v_ext_s >= VS_BEG_C) && (v_ext_s < VS_END_C);
    ctl_s    = {
      (h_ext_s < H_DISP_C) && (v_ext_s < V_DISP_C),
      hs_act_s ? HS_POL : ~HS_POL,
      vs_act_s ? VS_POL : ~VS_POL,
      (h_r == {CNT_W{1'b0}}) && (v_r == {CNT_W{1'b0}}),
      (h_r == H_DLAST_C) && (v_ext_s < V_DISP_C),
      (h_r == H_DLAST_C) && (v_r == V_DLAST_C)
    };
  end

  // Horizontal and vertical raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_r <= {CNT_W{1'b0}};
      v_r <= {CNT_W{1'b0}};
    end else if (bus.en) begin
      if (h_last_s) begin
        h_r <= {CNT_W{1'b0}};
        v_r <= v_last_s ? {CNT_W{1'b0}} : v_r + CNT_W'(1);
      end else begin
        h_r <= h_r + CNT_W'(1);
      end
    end
  end

  // Undelayed position and frame count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x_r     <= {CNT_W{1'b0}};
      pix_y_r     <= {CNT_W{1'b0}};
      frame_cnt_r <= {FRAME_W{1'b0}};
    end else if (bus.en) begin
      pix_x_r <= h_r;
      pix_y_r <= v_r;
      if (h_last_s && v_last_s) begin
        frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
      end
    end
  end

  // Control word register followed by the PIPE_DLY-deep alignment chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= PIPE_DLY; i++) begin
        ctl_r[i] <= IDLE_C;
      end
    end else if (bus.en) begin
      ctl_r[0] <= ctl_s;
      for (int i = 1; i <= PIPE_DLY; i++) begin
        ctl_r[i] <= ctl_r[i-1];
      end
    end
  end

  assign bus.pix_x     = pix_x_r;
  assign bus.pix_y     = pix_y_r;
  assign bus.frame_cnt = frame_cnt_r;
  assign {bus.de, bus.hs, bus.vs, bus.sof, bus.eol, bus.eof} = ctl_r[PIPE_DLY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 raster: base, PIPE_DLY=3 and inverted-polarity/2-bit-frame instances.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int pc      = 0;   // en edges since reset release

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) if0 ();
  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) if3 ();
  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(2)) ifp ();

  assign if0.en = en;
  assign if3.en = en;
  assign ifp.en = en;

  vga_timing_gen #(
    .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0), .CNT_W(10), .FRAME_W(8)
  ) dut0 (.clk(clk), .rst(rst), .bus(if0));

  vga_timing_gen #(
    .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3), .CNT_W(10), .FRAME_W(8)
  ) dut3 (.clk(clk), .rst(rst), .bus(if3));

  vga_timing_gen #(
    .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0), .CNT_W(10), .FRAME_W(2)
  ) dutp (.clk(clk), .rst(rst), .bus(ifp));

  // Expected {de,hs,vs,sof,eol,eof} for active-low syncs at pixel index q (q<0: reset state).
  function automatic logic [5:0] model(input int q);
    int  x;
    int  y;
    logic de_e, hs_e, vs_e, sof_e, eol_e, eof_e;
    if (q < 0) return 6'b011000;
    x     = (q % 112) % 14;
    y     = (q % 112) / 14;
    de_e  = (x < 8) && (y < 4);
    hs_e  = !((x >= 10) && (x <= 12));
    vs_e  = !((y >= 5) && (y <= 6));
    sof_e = (x == 0) && (y == 0);
    eol_e = (x == 7) && (y < 4);
    eof_e = (x == 7) && (y == 3);
    return {de_e, hs_e, vs_e, sof_e, eol_e, eof_e};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at pc=%0d: got %0h, expected %0h", tag, pc, got, exp);
    end
  endtask

  task automatic check_all();
    int         q;
    int         ex;
    int         ey;
    logic [5:0] e0;
    logic [5:0] e3;
    q  = pc - 1;
    e0 = model(q);
    e3 = model(pc - 4);
    if (pc == 0) begin
      ex = 0;
      ey = 0;
    end else begin
      ex = (q % 112) % 14;
      ey = (q % 112) / 14;
    end
    chk("d0.pix_x", 32'(if0.pix_x), 32'(ex));
    chk("d0.pix_y", 32'(if0.pix_y), 32'(ey));
    chk("d0.de_hs_vs_sof_eol_eof", 32'({if0.de, if0.hs, if0.vs, if0.sof, if0.eol, if0.eof}), 32'(e0));
    chk("d0.frame_cnt", 32'(if0.frame_cnt), 32'((pc / 112) % 256));
    chk("d3.pix_x", 32'(if3.pix_x), 32'(ex));
    chk("d3.pix_y", 32'(if3.pix_y), 32'(ey));
    chk("d3.de_hs_vs_sof_eol_eof", 32'({if3.de, if3.hs, if3.vs, if3.sof, if3.eol, if3.eof}), 32'(e3));
    chk("d3.frame_cnt", 32'(if3.frame_cnt), 32'((pc / 112) % 256));
    chk("dp.pix_x", 32'(ifp.pix_x), 32'(ex));
    chk("dp.de_hs_vs_sof_eol_eof", 32'({ifp.de, ifp.hs, ifp.vs, ifp.sof, ifp.eol, ifp.eof}),
        32'(e0 ^ 6'b011000));
    chk("dp.frame_cnt", 32'(ifp.frame_cnt), 32'((pc / 112) % 4));
  endtask

  // One clock with the given enable; outputs checked on the following falling edge.
  task automatic cyc(input logic e);
    en = e;
    @(posedge clk);
    if (e && !rst) pc++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int   last_rise;
    logic prev_sof;

    rst = 1'b1;
    repeat (3) cyc(1'b1);
    rst = 1'b0;

    // Two full frames and a bit with en tied high.
    repeat (230) cyc(1'b1);

    // en every 4th clock for two frames; sof rises must be 448 clocks apart.
    last_rise = -1;
    prev_sof  = if0.sof;
    for (int k = 0; k < 896; k++) begin
      cyc((k % 4) == 0);
      if (if0.sof && !prev_sof) begin
        if (last_rise >= 0) chk("sof_period_clks", 32'(k - last_rise), 32'd448);
        last_rise = k;
      end
      prev_sof = if0.sof;
    end

    // Long enable gap: everything frozen.
    repeat (50) cyc(1'b0);
    repeat (30) cyc(1'b1);

    // Run to (9,5), inside vsync, then reset asynchronously between edges.
    for (int i = 0; i < 200 && ((pc - 1) % 112) != 79; i++) cyc(1'b1);
    chk("seek_pix_9_5", 32'((pc - 1) % 112), 32'd79);
    chk("vs_active_before_rst", 32'(if0.vs), 32'd0);
    rst = 1'b1;
    pc  = 0;
    #1;
    check_all();
    repeat (2) cyc(1'b1);
    rst = 1'b0;
    repeat (120) cyc(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator that replaces the fixed 640x480 timing counter in the display path. Every porch and sync width is a parameter, sync polarity is selectable, and the counters advance only on a pixel-clock enable, so the block runs from the system clock. It outputs registered pixel coordinates and registered sync/data-enable signals. Sync, enable and strobe outputs have a programmable extra delay to match the pixel pipeline (tile/sprite ROM lookups) downstream. It also provides frame/line strobes and a frame counter for the game renderer.

## Interface
- H_DISP, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISP, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, active level of hs (0 = active-low)
- VS_POL, 0, active level of vs
- PIPE_DLY, 0, extra pixel-periods of delay on de/hs/vs/sof/eol/eof (0..7)
- CNT_W, 10, width of counters and pix_x/pix_y
- FRAME_W, 8, width of frame_cnt
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- en  in  1  pixel-clock enable; all state advances only when en=1
- pix_x  out  CNT_W  horizontal position of the current output pixel
- pix_y  out  CNT_W  vertical position of the current output pixel
- de  out  1  active-video enable
- hs  out  1  horizontal sync, level per HS_POL
- vs  out  1  vertical sync, level per VS_POL
- sof  out  1  start-of-frame strobe, pixel (0,0)
- eol  out  1  last active pixel of an active line
- eof  out  1  last active pixel of the frame
- frame_cnt  out  FRAME_W  completed-frame count, wraps

## Operation
- H_TOTAL = H_DISP+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Both must be ≤ 2^CNT_W. All parameters ≥ 1. PIPE_DLY ≤ 7.
- Line order: display, front porch, sync, back porch. Frame order is the same. Active video starts at count 0.
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1).
- On each en cycle: output registers load the decode of (h,v), then h increments. At h=H_TOTAL-1, h wraps to 0 and v increments. At v=V_TOTAL-1 with h=H_TOTAL-1, v wraps to 0 and frame_cnt increments modulo 2^FRAME_W.
- Decode of (h,v):
  - de = h<H_DISP and v<V_DISP.
  - hs active when H_DISP+H_FRONT ≤ h < H_DISP+H_FRONT+H_SYNC.
  - vs active when V_DISP+V_FRONT ≤ v < V_DISP+V_FRONT+V_SYNC, for every h of those lines.
  - sof = (h==0 and v==0).
  - eol = (h==H_DISP-1 and v<V_DISP).
  - eof = (h==H_DISP-1 and v==V_DISP-1).
  - pix_x=h, pix_y=v.
- Delay chain: de, hs, vs, sof, eol and eof pass through PIPE_DLY further registers that shift only on en. pix_x, pix_y and frame_cnt are never delayed; they lead the delayed signals by PIPE_DLY pixel periods.
- en=0: every register holds, so outputs are frozen indefinitely.

## Timing
- Reset (asynchronous, any time, including mid-line):
  - h=v=0, pix_x=pix_y=0, frame_cnt=0.
  - de=sof=eol=eof=0; every delay stage cleared to the same inactive values.
  - hs=~HS_POL, vs=~VS_POL.
- Latency: the first en cycle after reset release loads position (0,0), so pix_x/pix_y=(0,0) from the next clk edge. With PIPE_DLY=0, de=1 and sof=1 from that same edge. With PIPE_DLY=k, de/sof appear after the (k+1)-th en cycle.
- Strobes are pixel-period wide: asserted from the en cycle that loads them until the next en cycle. With en tied high they are exactly one clk wide.
- sof and eof never coincide. eol and eof coincide on the last active line.
- hs toggles independently of v, including during vertical blanking.

## Test plan
Small timing for all scenarios: H=8/2/3/1 (H_TOTAL 14), V=4/1/2/1 (V_TOTAL 8), 112 pixels per frame. en=1 unless stated.
- Reset and first frame, PIPE_DLY=0:
  - During rst: hs=vs=1, de=0, pix=(0,0).
  - After release, first edge: de=1, sof=1, pix=(0,0).
  - hs low for pix_x 10..12 on every line.
  - vs low for pix_y 5..6, all 14 pixels of each of those lines.
- Line/frame boundaries:
  - eol high at pix_x=7 on lines 0..3 only.
  - eof high only at (7,3).
  - pix_x wraps 13→0 with pix_y incrementing.
  - At (13,7)→(0,0): frame_cnt 0→1, then sof.
- en=1 every 4th clk:
  - Each output holds 4 clks; sof is 4 clks wide.
  - Frame length 448 clks.
  - Holding en=0 for 50 clks freezes all outputs.
- PIPE_DLY=3:
  - de/hs/vs/sof lag pix_x by exactly 3 pixels: sof asserts while pix=(3,0), and de falls while pix_x=11.
  - Delayed outputs match the PIPE_DLY=0 sequence shifted by 3.
- Polarity and wrap:
  - HS_POL=1, VS_POL=1: hs/vs are inverted relative to the first scenario; reset levels are 0.
  - FRAME_W=2: after 4 frames frame_cnt wraps 3→0.
- Reset mid-operation: assert rst at pix=(9,5) during vs active.
  - Immediately: hs=vs inactive, delay chain cleared, frame_cnt=0.
  - After release, the sequence restarts exactly as in the first scenario.
